// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Op codes, FSM state type and helpers shared by the HI/LO MDU.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int c_op_width = 3;

  typedef enum logic [c_op_width-1:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    MADD  = 3'd2,
    MADDU = 3'd3,
    MSUB  = 3'd4,
    MSUBU = 3'd5,
    MTHI  = 3'd6,
    MTLO  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } mdu_state_e;

  function automatic logic is_signed(input mdu_op_e op);
    return (op == MULT) || (op == MADD) || (op == MSUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_hilo_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_hilo_acc_if
// Description : Request/response bundle between the EX stage and the HI/LO MDU.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_hilo_acc_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic                  i_start;
  logic [c_op_width-1:0] i_op;
  logic [WIDTH-1:0]      i_rs;
  logic [WIDTH-1:0]      i_rt;
  logic                  i_flush;
  logic                  o_busy;
  logic                  o_done;
  logic [WIDTH-1:0]      o_hi;
  logic [WIDTH-1:0]      o_lo;

  modport master (
    output i_start, i_op, i_rs, i_rt, i_flush,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_rs, i_rt, i_flush,
    output o_busy, o_done, o_hi, o_lo
  );

endinterface
`default_nettype wire

// File: rtl/mdu_shift_mul.sv
`default_nettype none
// ============================================================================
// Module      : mdu_shift_mul
// Description : Unsigned WIDTH x WIDTH multiplier core, one shift-add per step.
//               MDU_FAST_MUL_EN selects a registered single-cycle multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_shift_mul #(
  parameter int WIDTH = 32
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_load,
  input  wire logic               i_step,
  input  wire logic [WIDTH-1:0]   i_a,
  input  wire logic [WIDTH-1:0]   i_b,
  output logic      [2*WIDTH-1:0] o_prod,
  output logic                    o_last
);

`ifdef MDU_FAST_MUL_EN

  logic [2*WIDTH-1:0] r_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= '0;
    end else if (i_load) begin
      r_prod <= {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    end
  end

  assign o_prod = r_prod;
  assign o_last = 1'b1;

`else

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [c_cnt_w-1:0] r_cnt;

  // Multiplicand walks left while the multiplier drains from its LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_prod   <= '0;
      r_cnt    <= c_cnt_w'(WIDTH - 1);
    end else if (i_step) begin
      if (r_mplier[0]) begin
        r_prod <= r_prod + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_prod = r_prod;
  assign o_last = (r_cnt == '0);

`endif

endmodule
`default_nettype wire

// File: rtl/mdu_hilo_acc.sv
`default_nettype none
// ============================================================================
// Module      : mdu_hilo_acc
// Description : Sequential MULT/MADD/MSUB unit owning HI/LO, with MTHI/MTLO.
//               MDU_FAST_MUL_EN replaces the iterative multiply with one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_hilo_acc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input wire logic     clk,
  input wire logic     rst,
  mdu_hilo_acc_if.slave bus
);

  mdu_state_e         r_state, w_state_nxt;
  mdu_op_e            r_op, w_op_in;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic               r_done, w_done_nxt;
  logic               w_load, w_step, w_last, w_sgn;
  logic [WIDTH-1:0]   w_mag_rs, w_mag_rt;
  logic [2*WIDTH-1:0] w_prod, w_p, w_acc, w_sum;

  assign w_op_in  = mdu_op_e'(bus.i_op);
  assign w_sgn    = is_signed(w_op_in);
  // Magnitude of the most-negative value is 2^(WIDTH-1), still exact unsigned.
  assign w_mag_rs = (w_sgn && bus.i_rs[WIDTH-1]) ? -bus.i_rs : bus.i_rs;
  assign w_mag_rt = (w_sgn && bus.i_rt[WIDTH-1]) ? -bus.i_rt : bus.i_rt;

  mdu_shift_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_a    (w_mag_rs),
    .i_b    (w_mag_rt),
    .o_prod (w_prod),
    .o_last (w_last)
  );

  assign w_p   = r_neg ? -w_prod : w_prod;
  assign w_acc = {r_hi, r_lo};

  always_comb begin
    w_sum = w_p;
    case (r_op)
      MADD, MADDU: w_sum = w_acc + w_p;
      MSUB, MSUBU: w_sum = w_acc - w_p;
      default:     w_sum = w_p;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        // A flush in IDLE drops a coincident request.
        if (bus.i_start && !bus.i_flush) begin
          case (w_op_in)
            MTHI: begin
              w_hi_nxt   = bus.i_rs;
              w_done_nxt = 1'b1;
            end
            MTLO: begin
              w_lo_nxt   = bus.i_rs;
              w_done_nxt = 1'b1;
            end
            default: begin
              w_load = 1'b1;
`ifdef MDU_FAST_MUL_EN
              w_state_nxt = ACC;
`else
              w_state_nxt = MUL;
`endif
            end
          endcase
        end
      end
      MUL: begin
        w_step = 1'b1;
        if (bus.i_flush) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = ACC;
        end
      end
      ACC: begin
        w_state_nxt = IDLE;
        if (!bus.i_flush) begin
          {w_hi_nxt, w_lo_nxt} = w_sum;
          w_done_nxt           = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_op    <= MULT;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_op  <= w_op_in;
        r_neg <= w_sgn & (bus.i_rs[WIDTH-1] ^ bus.i_rt[WIDTH-1]);
      end
    end
  end

  assign bus.o_busy = (r_state != IDLE);
  assign bus.o_done = r_done;
  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_hilo_acc
// Description : Self-checking bench for mdu_hilo_acc against a 64-bit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo_acc;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = W + 1;
`endif
  localparam int FL = (LAT > 10) ? 10 : 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_hilo_acc_if #(.WIDTH(W)) bus ();

  mdu_hilo_acc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_chk = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural result computed with plain 64-bit arithmetic.
  function automatic logic [63:0] f_result(input logic [2:0] op, input logic [31:0] rs,
                                           input logic [31:0] rt, input logic [63:0] acc);
    logic [63:0] p;
    if (op == 3'd0 || op == 3'd2 || op == 3'd4)
      p = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    else
      p = {32'd0, rs} * {32'd0, rt};
    case (op)
      3'd2, 3'd3: return acc + p;
      3'd4, 3'd5: return acc - p;
      default:    return p;
    endcase
  endfunction

  logic [63:0] m_acc, m_pend;
  int          m_left;
  logic        m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_acc  <= '0;
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      if (bus.i_flush) begin
        m_left <= 0;
        m_done <= 1'b0;
      end else if (m_left == 1) begin
        m_acc  <= m_pend;
        m_done <= 1'b1;
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.i_start && !bus.i_flush) begin
        if (bus.i_op == 3'd6) begin
          m_acc[63:32] <= bus.i_rs;
          m_done       <= 1'b1;
        end else if (bus.i_op == 3'd7) begin
          m_acc[31:0] <= bus.i_rs;
          m_done      <= 1'b1;
        end else begin
          m_pend <= f_result(bus.i_op, bus.i_rs, bus.i_rt, m_acc);
          m_left <= LAT;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {63'd0, bus.o_busy}, {63'd0, (m_left != 0)});
      chk("model_done", {63'd0, bus.o_done}, {63'd0, m_done});
      chk("model_hi", {32'd0, bus.o_hi}, {32'd0, m_acc[63:32]});
      chk("model_lo", {32'd0, bus.o_lo}, {32'd0, m_acc[31:0]});
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input int exp_busy, input string nm);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_rs    = rs;
    bus.i_rt    = rt;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.o_busy) nb++;
      if (bus.o_done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, {63'd0, seen}, 64'd1);
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    chk({nm, "_hi"}, {32'd0, bus.o_hi}, {32'd0, exp_hi});
    chk({nm, "_lo"}, {32'd0, bus.o_lo}, {32'd0, exp_lo});
    @(negedge clk);
    chk({nm, "_done_pulse"}, {63'd0, bus.o_done}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_start = 1'b0;
    bus.i_op    = MULT;
    bus.i_rs    = '0;
    bus.i_rt    = '0;
    bus.i_flush = 1'b0;
    rst         = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", {32'd0, bus.o_hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.o_lo}, 64'd0);
    chk("rst_busy", {63'd0, bus.o_busy}, 64'd0);
    chk("rst_done", {63'd0, bus.o_done}, 64'd0);

    do_op(MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT, "mult_neg3x5");
    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT, "multu_max");
    do_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, LAT, "mult_minneg");
    do_op(MTLO,  32'hFFFF_FFFF, 32'd0, 32'h4000_0000, 32'hFFFF_FFFF, 0, "mtlo");
    do_op(MTHI,  32'h0, 32'd0, 32'h0, 32'hFFFF_FFFF, 0, "mthi");
    do_op(MADDU, 32'd1, 32'd1, 32'h1, 32'h0, LAT, "maddu_carry");
    do_op(MULTU, 32'd0, 32'd0, 32'h0, 32'h0, LAT, "clear");
    do_op(MSUBU, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, "msubu_wrap");
    do_op(MSUB,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, "msub_m1m1");

    // Flush mid-operation, with ignored starts while busy
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_op = MADD; bus.i_rs = 32'd7; bus.i_rt = 32'd7;
    @(posedge clk); #1;
    repeat (FL - 1) begin
      bus.i_start = 1'b1; bus.i_op = MULTU; bus.i_rs = 32'd3; bus.i_rt = 32'd3;
      @(posedge clk); #1;
    end
    bus.i_start = 1'b0;
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {63'd0, bus.o_busy}, 64'd0);
    chk("flush_done", {63'd0, bus.o_done}, 64'd0);
    chk("flush_hi", {32'd0, bus.o_hi}, 64'hFFFF_FFFF);
    chk("flush_lo", {32'd0, bus.o_lo}, 64'hFFFF_FFFE);
    @(negedge clk);
    chk("flush_nodone", {63'd0, bus.o_done}, 64'd0);

    // Flush in IDLE drops a coincident request
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_flush = 1'b1; bus.i_op = MTHI; bus.i_rs = 32'h1234;
    @(posedge clk); #1;
    bus.i_start = 1'b0; bus.i_flush = 1'b0;
    @(negedge clk);
    chk("idleflush_done", {63'd0, bus.o_done}, 64'd0);
    chk("idleflush_hi", {32'd0, bus.o_hi}, 64'hFFFF_FFFF);

    // Reset in the middle of an operation
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_op = MADD; bus.i_rs = 32'd7; bus.i_rt = 32'd7;
    @(posedge clk); #1;
    bus.i_op = MULT; bus.i_rs = 32'd2; bus.i_rt = 32'd2;
    repeat (4) begin @(posedge clk); #1; end
    bus.i_start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_hi", {32'd0, bus.o_hi}, 64'd0);
    chk("midrst_lo", {32'd0, bus.o_lo}, 64'd0);
    chk("midrst_busy", {63'd0, bus.o_busy}, 64'd0);
    chk("midrst_done", {63'd0, bus.o_done}, 64'd0);

    // Randomized traffic against the model
    repeat (2500) begin
      @(posedge clk); #1;
      bus.i_start = ($urandom_range(0, 3) == 0);
      bus.i_op    = 3'($urandom_range(0, 7));
      bus.i_rs    = pick();
      bus.i_rt    = pick();
      bus.i_flush = ($urandom_range(0, 63) == 0);
      rst         = ($urandom_range(0, 599) == 0);
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    rst         = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_hilo_acc.md
# mdu_hilo_acc

Parametrised multiply/accumulate unit owning the architectural HI/LO register pair. It executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU with an iterative shift-add multiplier over several cycles, plus single-cycle MTHI/MTLO writes. It sits beside the EX stage and replaces the combinational HI/LO add/subtract stage with a self-contained sequential unit. Handshake: start/busy/done, plus a flush for exceptions.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the product and accumulator are 2*WIDTH bits.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  request; sampled only when o_busy=0.
- i_op  in  3  operation code from mdu_pkg: MULT=0, MULTU=1, MADD=2, MADDU=3, MSUB=4, MSUBU=5, MTHI=6, MTLO=7.
- i_rs  in  WIDTH  multiplicand, or the MTHI/MTLO data.
- i_rt  in  WIDTH  multiplier; ignored for MTHI/MTLO.
- i_flush  in  1  abort the in-flight operation; HI/LO are not written.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse after HI/LO are written.
- o_hi  out  WIDTH  registered HI.
- o_lo  out  WIDTH  registered LO.

## Operation
- States: IDLE, MUL, ACC.
- Reset values: state=IDLE, o_hi=0, o_lo=0, o_busy=0, o_done=0, counter=0.
- **IDLE**
  - Accept when i_start=1.
  - Op MTHI/MTLO: write i_rs to HI (MTHI) or LO (MTLO) on this edge; remain in IDLE; o_done=1 next cycle.
  - Any other op: latch operands and move to MUL.
- **Operand latch**
  - Signed ops (MULT, MADD, MSUB): latch |rs| and |rt|, with neg = rs[W-1] ^ rt[W-1].
  - Unsigned ops: latch raw values, with neg=0.
  - Latch the op code; load counter = WIDTH-1.
- **MUL**: WIDTH shift-add steps, one per cycle, into a 2W-bit unsigned partial product. After the step with counter=0, go to ACC.
- **ACC**
  - p = neg ? -prod : prod, taken mod 2^(2W).
  - MULT/MULTU: {HI,LO} = p.
  - MADD/MADDU: {HI,LO} = {HI,LO} + p.
  - MSUB/MSUBU: {HI,LO} = {HI,LO} - p.
  - All arithmetic is 2W-bit; carry/borrow out of bit 2W-1 is discarded (wrap).
  - Go to IDLE; o_done=1 next cycle.
- i_start while o_busy=1 is ignored; it is not queued. The upstream stage stalls on o_busy.
- i_flush=1 in MUL or ACC:
  - Next state IDLE; HI/LO unchanged; no o_done.
  - Flush beats the ACC write when both fall on the same edge.
- i_flush in IDLE: no effect, except that it takes priority over i_start (the request is dropped).
- rst mid-operation: everything returns to its reset values on that edge, including HI/LO=0.
- The most-negative operand (e.g. 0x80000000) has magnitude 2^(W-1), which fits unsigned in W bits; the signed product is correct.

## Timing
- Start accepted at edge E0 (MUL ops).
- Edges E1..EW perform the shift-add steps; the state is ACC after EW.
- HI/LO are written at E(W+1).
- o_busy=1 for exactly W+1 cycles, between E0 and E(W+1).
- o_done=1 for the one cycle after E(W+1), with o_busy=0 in that cycle. A new start may be sampled at E(W+2).
- MTHI/MTLO: written at E0; o_busy stays 0; o_done in the cycle after E0.
- o_hi/o_lo change only at write edges. They show the new value in the same cycle o_done is high.

## Configuration
- MDU_FAST_MUL_EN defined:
  - MUL is replaced by a single-cycle full 2W-bit multiply latched at E0.
  - The state goes IDLE→ACC directly; HI/LO are written at E1; o_busy=1 for 1 cycle; o_done in the cycle after E1.
  - Flush, sign, accumulate and wrap rules are unchanged.
- Undefined: the iterative W+1-cycle path above.

## Structure
- Package mdu_pkg holds:
  - the op-code localparams/typedef (3-bit);
  - the state typedef (IDLE/MUL/ACC);
  - a helper function is_signed(op).
- Sub-module mdu_shift_mul holds the iterative unsigned multiplier core:
  - start/operands in, counter, 2W-bit product out, last-step flag;
  - under MDU_FAST_MUL_EN it is a registered single-cycle multiply.
- The top level holds the FSM, sign handling, the accumulate adder/subtractor, and the HI/LO registers.

## Test plan (WIDTH=32)
- MULT rs=0xFFFFFFFD (-3), rt=5 → after 33 busy cycles: HI=0xFFFFFFFF, LO=0xFFFFFFF1, one o_done pulse.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- MTLO 0xFFFFFFFF, MTHI 0, then MADDU 1×1 → HI=1, LO=0 (carry from LO into HI).
- With HI=LO=0: MSUBU 1×1 → HI=LO=0xFFFFFFFF (wrap). Then MSUB (-1)×(-1) → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MADD 7×7 with i_flush at cycle 10 → o_busy=0 next cycle, no o_done, HI/LO unchanged. i_start during busy is ignored; rst at cycle 5 → HI=LO=0, IDLE.
- With MDU_FAST_MUL_EN defined: repeat the first case → o_busy exactly 1 cycle, same HI/LO values.
